sram_controller: RTL and testbench



---
 rtl/sram_pkg.sv | 28 ++
 rtl/sram_phase_counter.sv | 38 +++
 rtl/sram_controller.sv | 140 ++++++++++++++
 tb/tb_sram_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared types and defaults for the 16-bit async SRAM controller.
// Revision : 1.0  initial release
// ============================================================================
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int c_ADDR_BASE   = 1024;
    localparam int c_SRAM_ADDR_W = 18;
    localparam int c_WAIT_CYCLES = 2;
    localparam int c_CNT_W       = 4;

    // Byte offset of a pipeline address from the start of the data region.
    function automatic logic [31:0] byte_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_phase_counter.sv
`default_nettype none
// ============================================================================
// Module   : sram_phase_counter
// Brief    : Wait counter 0..WAIT_CYCLES-1 with clear and terminal count.
// Revision : 1.0  initial release
// ============================================================================
module sram_phase_counter
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = c_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            // Wrap at terminal count so the next phase starts from zero.
            r_count <= tc ? '0 : r_count + c_ONE;
        end
    end

    assign tc = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Brief    : Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM accesses.
// Revision : 1.0  initial release
// ============================================================================
module sram_controller
    import sram_pkg::*;
#(
    parameter int ADDR_BASE   = c_ADDR_BASE,
    parameter int SRAM_ADDR_W = c_SRAM_ADDR_W,
    parameter int WAIT_CYCLES = c_WAIT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    sram_state_t            r_state;
    logic                   r_is_write;
    logic [SRAM_ADDR_W-2:0] r_word;
    logic [15:0]            r_wdata_hi;
    logic [31:0]            r_read_data;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic                   r_we_n;
    logic                   r_oe_n;
    logic                   r_ce_n;
    logic                   r_dq_oe;
    logic [15:0]            r_dq_out;

    logic                   w_req;
    logic                   w_phase;
    logic                   w_tc;
    logic [31:0]            w_offset;
    logic [SRAM_ADDR_W-2:0] w_word;
    logic                   w_unused_offset;

    assign w_req    = rd_en | wr_en;
    assign w_phase  = (r_state == LOW) || (r_state == HIGH);
    assign w_offset = byte_offset(address, 32'(ADDR_BASE));
    // Bits outside the halfword-pair index wrap away modulo the SRAM size.
    assign w_word          = w_offset[SRAM_ADDR_W:2];
    assign w_unused_offset = ^{w_offset[31:SRAM_ADDR_W+1], w_offset[1:0]};

    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_counter (
        .clk (clk),
        .rst (rst),
        .clr (~w_phase),
        .en  (w_phase),
        .tc  (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_write  <= 1'b0;
            r_word      <= '0;
            r_wdata_hi  <= '0;
            r_read_data <= '0;
            r_addr      <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_ce_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // Write wins when both requests are present.
                        r_is_write <= wr_en;
                        r_word     <= w_word;
                        r_wdata_hi <= write_data[31:16];
                        r_addr     <= {w_word, 1'b0};
                        r_ce_n     <= 1'b0;
                        r_we_n     <= ~wr_en;
                        r_oe_n     <= wr_en;
                        r_dq_oe    <= wr_en;
                        r_dq_out   <= write_data[15:0];
                        r_state    <= LOW;
                    end
                end
                LOW: begin
                    if (w_tc) begin
                        if (!r_is_write) begin
                            r_read_data[15:0] <= SRAM_DQ;
                        end
                        r_addr   <= {r_word, 1'b1};
                        r_dq_out <= r_wdata_hi;
                        r_state  <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_tc) begin
                        if (!r_is_write) begin
                            r_read_data[31:16] <= SRAM_DQ;
                        end
                        r_ce_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'hzzzz;
    assign SRAM_ADDR = r_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_UB_N = r_ce_n;
    assign SRAM_LB_N = r_ce_n;
    assign read_data = r_read_data;
    assign ready     = ~w_req | (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Brief    : Directed bench for sram_controller with a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_controller;

    localparam int c_W    = 2;
    localparam int c_BASE = 1024;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    sram_controller #(
        .ADDR_BASE   (c_BASE),
        .SRAM_ADDR_W (18),
        .WAIT_CYCLES (c_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SRAM: combinational read, write on clock while WE_N is low.
    logic [15:0] sram_mem [0:1023];
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_mem[SRAM_ADDR[9:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) sram_mem[SRAM_ADDR[9:0]] <= SRAM_DQ;
    end

    // Bus probe: drives zero whenever nobody else may drive, exposing stray DUT drive.
    logic probe_en;
    assign SRAM_DQ = probe_en ? 16'h0000 : 16'hzzzz;

    int passed;
    int total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: position within an access (0 = idle, 1..2W+1 = LOW/HIGH/DONE).
    int          m_k;
    logic        m_wr;
    logic [16:0] m_word;
    logic [31:0] m_wdata;
    logic [31:0] m_rd;
    logic [15:0] m_mem [0:1023];
    int          oe_cnt;
    int          we_cnt;
    int          n_log;
    logic [17:0] addr_log [0:255];

    function automatic bit m_active();
        return (m_k >= 1) && (m_k <= 2 * c_W);
    endfunction

    task automatic model_step();
        logic [31:0] off;
        logic [17:0] ha;
        if (m_k == 0) begin
            if (rd_en || wr_en) begin
                off     = address - 32'(c_BASE);
                m_word  = off[18:2];
                m_wr    = wr_en;
                m_wdata = write_data;
                m_k     = 1;
            end
        end else begin
            if (m_k == c_W) begin
                ha = {m_word, 1'b0};
                if (m_wr) m_mem[ha[9:0]] = m_wdata[15:0];
                else      m_rd[15:0]     = m_mem[ha[9:0]];
            end else if (m_k == 2 * c_W) begin
                ha = {m_word, 1'b1};
                if (m_wr) m_mem[ha[9:0]] = m_wdata[31:16];
                else      m_rd[31:16]    = m_mem[ha[9:0]];
            end
            m_k = (m_k == 2 * c_W + 1) ? 0 : m_k + 1;
        end
    endtask

    task automatic check_cycle();
        bit          act;
        bit          hi;
        logic [17:0] ha;
        logic [15:0] exp_dq;
        act = m_active();
        hi  = (m_k > c_W);
        ha  = {m_word, hi};
        chk("ce_n", 32'(SRAM_CE_N), 32'(!act));
        chk("ub_n", 32'(SRAM_UB_N), 32'(!act));
        chk("lb_n", 32'(SRAM_LB_N), 32'(!act));
        chk("we_n", 32'(SRAM_WE_N), 32'(!(act && m_wr)));
        chk("oe_n", 32'(SRAM_OE_N), 32'(!(act && !m_wr)));
        chk("ready", 32'(ready), 32'(!(rd_en || wr_en) || (m_k == 2 * c_W + 1)));
        chk("read_data", read_data, m_rd);
        if (act) begin
            chk("sram_addr", 32'(SRAM_ADDR), 32'(ha));
            if (m_wr) exp_dq = hi ? m_wdata[31:16] : m_wdata[15:0];
            else      exp_dq = m_mem[ha[9:0]];
            chk("sram_dq", 32'(SRAM_DQ), 32'(exp_dq));
        end else begin
            chk("sram_dq_released", 32'(SRAM_DQ), 32'h0);
        end
        if (!SRAM_OE_N) oe_cnt++;
        if (!SRAM_WE_N) we_cnt++;
        if (!SRAM_CE_N && n_log < 256) begin
            addr_log[n_log] = SRAM_ADDR;
            n_log++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = 16'h0;
            m_mem[i]    = 16'h0;
        end
        m_k = 0; m_wr = 1'b0; m_word = '0; m_wdata = '0; m_rd = '0;
        oe_cnt = 0; we_cnt = 0; n_log = 0;
        probe_en = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_k  = 0;
                m_rd = '0;
            end
            probe_en = !m_active();
            #1;
            check_cycle();
            @(posedge clk);
            if (!rst) model_step();
            probe_en = !m_active();
        end
    end

    // Drives one request from cycle 0 until ready, then releases it; returns cycles to ready.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    int lat;
    int oe0;
    int we0;
    int log0;

    initial begin
        passed = 0; total = 0;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'h0);
        chk("rst_strobes", 32'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1f);
        chk("rst_ready", 32'(ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Write 0xDEADBEEF to word 0.
        we0 = we_cnt;
        run_op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat);
        chk("wr_latency", 32'(lat), 32'd5);
        chk("wr_we_cycles", 32'(we_cnt - we0), 32'd4);
        chk("sram_hw0", 32'(sram_mem[0]), 32'h0000BEEF);
        chk("sram_hw1", 32'(sram_mem[1]), 32'h0000DEAD);

        // Read it back.
        oe0 = oe_cnt; we0 = we_cnt;
        run_op(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        chk("rd_latency", 32'(lat), 32'd5);
        chk("rd_data", read_data, 32'hDEADBEEF);
        chk("rd_oe_cycles", 32'(oe_cnt - oe0), 32'd4);
        chk("rd_we_cycles", 32'(we_cnt - we0), 32'd0);
        chk("model_rd", m_rd, 32'hDEADBEEF);

        // Address 1036 maps to halfwords 6 and 7.
        log0 = n_log;
        run_op(1'b0, 1'b1, 32'd1036, 32'h12345678, lat);
        chk("a1036_low", 32'(addr_log[log0]), 32'd6);
        chk("a1036_high", 32'(addr_log[log0 + c_W]), 32'd7);
        chk("sram_hw6", 32'(sram_mem[6]), 32'h00005678);
        chk("sram_hw7", 32'(sram_mem[7]), 32'h00001234);
        chk("model_word", 32'(m_word), 32'd3);

        // Address 1037 ignores the byte offset.
        log0 = n_log;
        run_op(1'b1, 1'b0, 32'd1037, 32'h0, lat);
        chk("a1037_low", 32'(addr_log[log0]), 32'd6);
        chk("a1037_high", 32'(addr_log[log0 + c_W]), 32'd7);
        chk("a1037_data", read_data, 32'h12345678);

        // Both requests: the write wins and read_data is untouched.
        oe0 = oe_cnt; we0 = we_cnt;
        run_op(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, lat);
        chk("both_we_cycles", 32'(we_cnt - we0), 32'd4);
        chk("both_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
        chk("both_read_data", read_data, 32'h12345678);
        chk("sram_hw2", 32'(sram_mem[2]), 32'h0000F00D);
        chk("sram_hw3", 32'(sram_mem[3]), 32'h0000CAFE);

        // Read dropped during LOW still completes.
        oe0 = oe_cnt;
        rd_en = 1'b1; address = 32'd1028;
        @(posedge clk); #1;
        rd_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("drop_oe_cycles", 32'(oe_cnt - oe0), 32'd4);
        chk("drop_read_data", read_data, 32'hCAFEF00D);
        chk("drop_ready", 32'(ready), 32'h1);
        chk("drop_ce_n", 32'(SRAM_CE_N), 32'h1);
        @(posedge clk); #1;

        // Reset during the HIGH phase of a write.
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hAAAA5555;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk); #2;
        chk("rstmid_strobes", 32'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1f);
        chk("rstmid_dq", 32'(SRAM_DQ), 32'h0);
        chk("rstmid_read_data", read_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'h1);
        chk("post_rst_ce_n", 32'(SRAM_CE_N), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
